// File: rtl/float_adder_ctrl_pkg.sv
// Shared types for the float adder arbiter: requester ID and tag pipe entry.
package float_adder_ctrl_pkg;

  localparam int ADD_LATENCY = 5;
  localparam int MAX_REQ     = 8;
  localparam int ID_W        = $clog2(MAX_REQ);

  typedef logic [ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    vld;
    req_id_t id;
  } add_tag_t;

endpackage

// File: rtl/float_adder_arbiter_rr.sv
// Combinational round-robin arbiter: one-hot grant to the first eligible index at or after ptr.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         eligible,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] idx_s;
  logic          found_s;

  // Scan from ptr with wrap-around; found_s masks every candidate after the first hit
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int off = 0; off < N; off++) begin
      idx_s        = PW'((int'(ptr) + off) % N);
      grant[idx_s] = grant[idx_s] | (eligible[idx_s] & ~found_s);
      found_s      = found_s | eligible[idx_s];
    end
  end

endmodule

// File: rtl/float_adder_arbiter.sv
// Shares one pipelined float adder between N_REQ requesters; a tag pipe aligned to the
// adder latency steers every sum back to the result slot of the requester that issued it.
module float_adder_arbiter
  import float_adder_ctrl_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int LATENCY = ADD_LATENCY,
  parameter int W       = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*W-1:0]           req_a,
  input  logic [N_REQ*W-1:0]           req_b,
  output logic [N_REQ-1:0]             req_ready,
  output logic [N_REQ-1:0]             res_valid,
  output logic [N_REQ*W-1:0]           res_data,
  input  logic [N_REQ-1:0]             res_ready,
  output logic                         add_rst_o,
  output logic                         add_inp_rdy,
  output logic [W-1:0]                 add_a,
  output logic [W-1:0]                 add_b,
  input  logic [W-1:0]                 add_sum,
  output logic [$clog2(LATENCY+1)-1:0] in_flight
);

  localparam int PW  = $clog2(N_REQ);
  localparam int IFW = $clog2(LATENCY+1);

  logic [N_REQ-1:0] busy_s;
  logic [N_REQ-1:0] eligible_s;
  logic [N_REQ-1:0] grant_s;
  logic [PW-1:0]    ptr_r;
  logic [PW-1:0]    gnt_idx_s;
  logic             handshake_s;
  logic [W-1:0]     sel_a_s;
  logic [W-1:0]     sel_b_s;
  add_tag_t         tag_in_s;
  add_tag_t         ret_tag_s;
  logic             retire_s;
  add_tag_t         tag_pipe_r [LATENCY+1];
  logic [N_REQ-1:0] res_valid_r;
  logic [W-1:0]     res_data_r [N_REQ];
  logic             add_inp_rdy_r;
  logic [W-1:0]     add_a_r;
  logic [W-1:0]     add_b_r;
  logic [IFW-1:0]   in_flight_r;

  // A requester stays busy from issue until its result slot has been drained
  always_comb begin
    busy_s = res_valid_r;
    for (int s = 0; s <= LATENCY; s++) begin
      for (int i = 0; i < N_REQ; i++) begin
        busy_s[i] = busy_s[i] | (tag_pipe_r[s].vld & (tag_pipe_r[s].id == ID_W'(i)));
      end
    end
  end

  assign eligible_s = req_valid & ~busy_s;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .eligible (eligible_s),
    .ptr      (ptr_r),
    .grant    (grant_s)
  );

  assign handshake_s = |(req_valid & grant_s);

  // Decode the one-hot grant into an index and the winner's operand pair
  always_comb begin
    gnt_idx_s = '0;
    sel_a_s   = '0;
    sel_b_s   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt_idx_s = gnt_idx_s | ({PW{grant_s[i]}} & PW'(i));
      sel_a_s   = sel_a_s | ({W{grant_s[i]}} & req_a[i*W +: W]);
      sel_b_s   = sel_b_s | ({W{grant_s[i]}} & req_b[i*W +: W]);
    end
  end

  assign tag_in_s  = {handshake_s, ID_W'(gnt_idx_s)};
  assign ret_tag_s = tag_pipe_r[LATENCY];
  assign retire_s  = ret_tag_s.vld;

  // Issue registers and round-robin pointer; operands hold between issues
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_r         <= '0;
      add_inp_rdy_r <= 1'b0;
      add_a_r       <= '0;
      add_b_r       <= '0;
    end else if (handshake_s) begin
      ptr_r         <= (gnt_idx_s == PW'(N_REQ-1)) ? '0 : gnt_idx_s + PW'(1);
      add_inp_rdy_r <= 1'b1;
      add_a_r       <= sel_a_s;
      add_b_r       <= sel_b_s;
    end else begin
      add_inp_rdy_r <= 1'b0;
    end
  end

  // Tag shift register: the entry at stage LATENCY lines up with add_sum
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s <= LATENCY; s++) begin
        tag_pipe_r[s] <= '0;
      end
    end else begin
      tag_pipe_r[0] <= tag_in_s;
      for (int s = 1; s <= LATENCY; s++) begin
        tag_pipe_r[s] <= tag_pipe_r[s-1];
      end
    end
  end

  // Result slots; a retiring write and a drain never target the same slot
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_valid_r <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        res_data_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (retire_s && (ret_tag_s.id == ID_W'(i))) begin
          res_valid_r[i] <= 1'b1;
          res_data_r[i]  <= add_sum;
        end else if (res_valid_r[i] && res_ready[i]) begin
          res_valid_r[i] <= 1'b0;
        end else begin
          res_valid_r[i] <= res_valid_r[i];
        end
      end
    end
  end

  // Occupancy counter tracking the valid entries of the tag pipe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_flight_r <= '0;
    end else begin
      case ({handshake_s, retire_s})
        2'b10:   in_flight_r <= in_flight_r + IFW'(1);
        2'b01:   in_flight_r <= in_flight_r - IFW'(1);
        default: in_flight_r <= in_flight_r;
      endcase
    end
  end

  assign req_ready   = grant_s;
  assign res_valid   = res_valid_r;
  assign add_rst_o   = rst_i;
  assign add_inp_rdy = add_inp_rdy_r;
  assign add_a       = add_a_r;
  assign add_b       = add_b_r;
  assign in_flight   = in_flight_r;

  for (genvar g = 0; g < N_REQ; g++) begin : g_res
    assign res_data[g*W +: W] = res_data_r[g];
  end

endmodule

// File: tb/tb_float_adder_arbiter.sv
// Directed bench for float_adder_arbiter with a 5-stage adder stand-in that knows the test sums.
module tb_float_adder_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_ready;
  logic [3:0]   res_valid;
  logic [127:0] res_data;
  logic [3:0]   res_ready;
  logic         add_rst_o;
  logic         add_inp_rdy;
  logic [31:0]  add_a;
  logic [31:0]  add_b;
  logic [31:0]  add_sum;
  logic [2:0]   in_flight;

  int errors = 0;
  int checks = 0;

  float_adder_arbiter #(.N_REQ(4), .LATENCY(5), .W(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_ready   (res_ready),
    .add_rst_o   (add_rst_o),
    .add_inp_rdy (add_inp_rdy),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_sum     (add_sum),
    .in_flight   (in_flight)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hand-computed IEEE-754 sums for the directed operands; plain integer add otherwise
  function automatic logic [31:0] fake_fadd(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] key;
    key = {a, b};
    case (key)
      64'h3F800000_40000000: return 32'h40400000;
      64'h3FC00000_3F000000: return 32'h40000000;
      64'hBF800000_3F800000: return 32'h00000000;
      default:               return a + b;
    endcase
  endfunction

  logic [31:0] add_pipe [5];
  always @(posedge clk) begin
    if (add_rst_o) begin
      for (int s = 0; s < 5; s++) add_pipe[s] <= 32'h0;
    end else begin
      add_pipe[0] <= add_inp_rdy ? fake_fadd(add_a, add_b) : 32'h0;
      for (int s = 1; s < 5; s++) add_pipe[s] <= add_pipe[s-1];
    end
  end
  assign add_sum = add_pipe[4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic hs_q = 1'b0;
  always @(posedge clk) hs_q <= rst ? 1'b0 : |(req_valid & req_ready);

  always @(negedge clk) begin
    check_eq("onehot0", 32'($onehot0(req_ready)), 32'h1);
    check_eq("inflight_max", 32'(in_flight <= 3'd5), 32'h1);
    check_eq("inp_rdy_vs_hs", 32'(add_inp_rdy), 32'(hs_q));
  end

  logic [3:0]  gnt_tbl [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
  logic [3:0]  bp_tbl  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0000};
  logic [31:0] sum_tbl [4] = '{32'h101, 32'h202, 32'h303, 32'h404};
  int          seen    [4];

  initial begin
    rst = 1'b1; req_valid = 4'b0; req_a = 128'h0; req_b = 128'h0; res_ready = 4'b0;
    repeat (2) tick();
    check_eq("rst_res_valid", 32'(res_valid), 32'h0);
    check_eq("rst_inp_rdy", 32'(add_inp_rdy), 32'h0);
    check_eq("rst_in_flight", 32'(in_flight), 32'h0);
    check_eq("rst_add_a", add_a, 32'h0);
    check_eq("rst_add_rst", 32'(add_rst_o), 32'h1);
    rst = 1'b0;

    // single op on requester 0
    req_valid = 4'b0001; req_a[31:0] = 32'h3F800000; req_b[31:0] = 32'h40000000;
    #1 check_eq("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0;
    check_eq("t1_inp_rdy", 32'(add_inp_rdy), 32'h1);
    check_eq("t1_add_a", add_a, 32'h3F800000);
    check_eq("t1_add_b", add_b, 32'h40000000);
    check_eq("t1_in_flight", 32'(in_flight), 32'h1);
    for (int n = 1; n <= 6; n++) begin
      tick();
      check_eq("t1_res_valid", 32'(res_valid[0]), (n == 6) ? 32'h1 : 32'h0);
    end
    check_eq("t1_res_data", res_data[31:0], 32'h40400000);
    check_eq("t1_in_flight_0", 32'(in_flight), 32'h0);
    res_ready = 4'b0001;
    tick();
    res_ready = 4'b0;
    check_eq("t1_drained", 32'(res_valid), 32'h0);

    // per-requester tagging, back-to-back issue from requesters 1 and 2
    req_a[63:32] = 32'h3FC00000; req_b[63:32] = 32'h3F000000;
    req_a[95:64] = 32'hBF800000; req_b[95:64] = 32'h3F800000;
    req_valid = 4'b0110;
    #1 check_eq("t3_ready1", 32'(req_ready), 32'h2);
    tick();
    check_eq("t3_ready2", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0;
    repeat (5) tick();
    check_eq("t3_valid_slot1", 32'(res_valid), 32'h2);
    tick();
    check_eq("t3_valid_both", 32'(res_valid), 32'h6);
    check_eq("t3_slot1", res_data[63:32], 32'h40000000);
    check_eq("t3_slot2", res_data[95:64], 32'h00000000);
    res_ready = 4'b0110;
    tick();
    res_ready = 4'b0;
    check_eq("t3_drained", 32'(res_valid), 32'h0);

    // all four requesting, pointer reset to 0, results drained immediately
    rst = 1'b1;
    tick();
    rst = 1'b0;
    res_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = 32'h100 * (i + 1);
      req_b[i*32 +: 32] = 32'(i + 1);
      seen[i] = 0;
    end
    for (int n = 0; n < 16; n++) begin
      req_valid = (n < 8) ? 4'b1111 : 4'b0000;
      #1;
      check_eq("t2_grant", 32'(req_ready), (n < 8) ? 32'(gnt_tbl[n]) : 32'h0);
      if (n == 4) check_eq("t2_in_flight", 32'(in_flight), 32'h4);
      for (int i = 0; i < 4; i++) begin
        if (res_valid[i]) begin
          seen[i]++;
          check_eq("t2_sum", res_data[i*32 +: 32], sum_tbl[i]);
        end
      end
      tick();
    end
    for (int i = 0; i < 4; i++) check_eq("t2_seen", 32'(seen[i]), 32'h1);

    // backpressure on requester 0
    res_ready = 4'b0;
    req_valid = 4'b0001;
    #1 check_eq("t4_ready0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0;
    repeat (6) tick();
    check_eq("t4_held", 32'(res_valid), 32'h1);
    res_ready = 4'b1110;
    req_valid = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      #1 check_eq("t4_grant", 32'(req_ready), 32'(bp_tbl[n]));
      tick();
    end
    res_ready = 4'b1111;
    #1 check_eq("t4_no_same_cycle", 32'(req_ready), 32'h0);
    tick();
    #1 check_eq("t4_regrant", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0;
    check_eq("t4_issue", 32'(add_inp_rdy), 32'h1);
    check_eq("t4_add_a", add_a, 32'h100);
    repeat (12) tick();
    check_eq("t4_empty", 32'(res_valid), 32'h0);
    check_eq("t4_in_flight", 32'(in_flight), 32'h0);

    // reset with three ops in flight
    req_valid = 4'b0111;
    repeat (3) tick();
    req_valid = 4'b0;
    check_eq("t5_in_flight", 32'(in_flight), 32'h3);
    rst = 1'b1;
    tick();
    check_eq("t5_inp_rdy", 32'(add_inp_rdy), 32'h0);
    check_eq("t5_add_a", add_a, 32'h0);
    check_eq("t5_add_b", add_b, 32'h0);
    check_eq("t5_in_flight_0", 32'(in_flight), 32'h0);
    check_eq("t5_res_valid", 32'(res_valid), 32'h0);
    check_eq("t5_ready", 32'(req_ready), 32'h0);
    check_eq("t5_add_rst", 32'(add_rst_o), 32'h1);
    rst = 1'b0;
    res_ready = 4'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      check_eq("t5_no_result", 32'(res_valid), 32'h0);
    end
    check_eq("t5_final_in_flight", 32'(in_flight), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
